// File: rtl/uart_fifo_pkg.sv
// Shared defaults and elaboration helpers for the thresholded UART FIFO.
package uart_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

  // One extra bit so a completely full FIFO (level == depth) is representable.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit thresholds_ok(input int af_level, input int ae_level,
                                       input int addr_width);
    int depth;
    depth = 2 ** addr_width;
    return (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_w_en,
  input  logic [ADDR_WIDTH-1:0] i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  output logic [DATA_WIDTH-1:0] o_r_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clock) begin
    if (i_w_en) begin
      mem[i_w_addr] <= i_w_data;
    end
  end

  assign o_r_data = mem[i_r_addr];

endmodule

// File: rtl/uart_fifo_thresh.sv
// Parametrised UART byte FIFO with fill-level thresholds, sticky error flags,
// synchronous flush and selectable FWFT / registered read output.
module uart_fifo_thresh
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_clear_err,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_r_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int LW = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] DEPTH_LV = LW'(2 ** ADDR_WIDTH);
  localparam logic [LW-1:0] AF_LV    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LV    = LW'(AE_LEVEL);

  if (!thresholds_ok(AF_LEVEL, AE_LEVEL, ADDR_WIDTH)) begin : g_bad_params
    $error("uart_fifo_thresh: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
  end

  logic [LW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          full, empty, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign full  = (level_reg == DEPTH_LV);
  assign empty = (level_reg == '0);

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign wr_ok = i_write && (!full || i_read);
  assign rd_ok = i_read && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
      if (wr_ok && !rd_ok)      level_next = level_reg + 1'b1;
      else if (rd_ok && !wr_ok) level_next = level_reg - 1'b1;
    end
  end

  // Set beats clear so an error in the clearing cycle is never lost.
  always_comb begin
    overflow_next  = (overflow_reg && !i_clear_err) || (i_write && full && !i_read);
    underflow_next = (underflow_reg && !i_clear_err) || (i_read && empty);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clock (i_clock),
    .i_w_en  (wr_ok && !i_flush),
    .i_w_addr(wr_ptr_reg[ADDR_WIDTH-1:0]),
    .i_w_data(i_w_data),
    .i_r_addr(rd_ptr_reg[ADDR_WIDTH-1:0]),
    .o_r_data(ram_rd_data)
  );

  if (FWFT) begin : g_fwft
    // Masked while empty so the output is a clean zero after reset or flush.
    assign o_r_data  = empty ? '0 : ram_rd_data;
    assign o_r_valid = !empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic                  r_valid_reg;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_data_reg  <= '0;
        r_valid_reg <= 1'b0;
      end else if (rd_ok && !i_flush) begin
        r_data_reg  <= ram_rd_data;
        r_valid_reg <= 1'b1;
      end else begin
        r_valid_reg <= 1'b0;
      end
    end

    assign o_r_data  = r_data_reg;
    assign o_r_valid = r_valid_reg;
  end

  assign o_empty        = empty;
  assign o_full         = full;
  assign o_almost_empty = (level_reg <= AE_LV);
  assign o_almost_full  = (level_reg >= AF_LV);
  assign o_level        = level_reg;
  assign o_overflow     = overflow_reg;
  assign o_underflow    = underflow_reg;

endmodule
